// File: rtl/votador_n.sv
// rtl/votador_n.sv - sequential N-voter ballot unit publishing a quorum result with tallies
// Optional veto input / vetoed output when VOTADOR_VETO_EN is defined.
module votador_n #(
  parameter int N       = 5,
  parameter int QUORUM  = 3,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef VOTADOR_VETO_EN
  input  logic                   veto,
  output logic                   vetoed,
`endif
  input  logic                   start,
  input  logic                   close,
  input  logic [N-1:0]           valid,
  input  logic [N-1:0]           vote,
  output logic                   busy,
  output logic                   done,
  output logic                   result,
  output logic [$clog2(N+1)-1:0] yes_count,
  output logic [$clog2(N+1)-1:0] cast_count
);

  localparam int W  = $clog2(N + 1);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0]  QUORUM_W   = W'(QUORUM);
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [N-1:0]  ALL_VOTED  = {N{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_OPEN, S_RESULT} state_e;

  state_e        state_q;
  logic [N-1:0]  voted_q;
  logic [W-1:0]  yes_q;
  logic [W-1:0]  cast_q;
  logic [TW-1:0] timer_q;
  logic          busy_q;
  logic          done_q;
  logic          result_q;

  logic [N-1:0]  new_mask;
  logic [N-1:0]  voted_d;
  logic [W-1:0]  yes_d;
  logic [W-1:0]  cast_d;
  logic          veto_hit;
  logic          timeout_hit;
  logic          end_hit;

  function automatic logic [W-1:0] popcount(input logic [N-1:0] bits);
    logic [W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + W'(bits[i]);
    end
    return cnt;
  endfunction

`ifdef VOTADOR_VETO_EN
  logic vetoed_q;
  assign veto_hit = veto;
  assign vetoed   = vetoed_q;
`else
  assign veto_hit = 1'b0;
`endif

  // Only first-time voters count; tallies and end test include this cycle's votes.
  always_comb begin
    new_mask    = valid & ~voted_q;
    voted_d     = voted_q | new_mask;
    yes_d       = yes_q + popcount(new_mask & vote);
    cast_d      = cast_q + popcount(new_mask);
    timeout_hit = (TIMEOUT > 0) && (timer_q == TIMER_LAST);
    end_hit     = (voted_d == ALL_VOTED) || close || timeout_hit || veto_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      voted_q  <= '0;
      yes_q    <= '0;
      cast_q   <= '0;
      timer_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
`ifdef VOTADOR_VETO_EN
      vetoed_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q  <= S_OPEN;
            voted_q  <= '0;
            yes_q    <= '0;
            cast_q   <= '0;
            timer_q  <= '0;
            result_q <= 1'b0;
            busy_q   <= 1'b1;
`ifdef VOTADOR_VETO_EN
            vetoed_q <= 1'b0;
`endif
          end
        end
        S_OPEN: begin
          voted_q <= voted_d;
          yes_q   <= yes_d;
          cast_q  <= cast_d;
          if (end_hit) begin
            state_q  <= S_RESULT;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= (yes_d >= QUORUM_W) && !veto_hit;
`ifdef VOTADOR_VETO_EN
            vetoed_q <= veto_hit;
`endif
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_RESULT: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign yes_count  = yes_q;
  assign cast_count = cast_q;

endmodule
